move_frame_tx: RTL and testbench
================================

# move_frame_tx

Transmit side of the referee move link. Accepts our computed Connect6 move (one or two stones on the 19x19 board) through a valid/ready handshake, range-checks it, and serialises it as a fixed 7-byte framed packet on a byte-wide valid/ready stream toward the link PHY. It is the counterpart of the board's opponent-move intake path: the board consumes decoded coordinate pairs, and this block produces them on the wire.

## Interface
- BOARD_SIZE, 19, legal coordinate range is 0..BOARD_SIZE-1
- SOF_BYTE, 8'hA5, frame start marker
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- move_valid  in  1  move request present
- move_ready  out  1  block can accept a move (IDLE only)
- move_single  in  1  1 = one-stone move (opening), stone 2 ignored
- move_x1, move_y1, move_x2, move_y2  in  6 each  stone coordinates
- tx_data  out  8  stream byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  downstream accepts byte
- tx_last  out  1  marks checksum byte (byte 6)
- err_range  out  1  one-cycle pulse: move rejected
- busy  out  1  frame in progress
- seq_num  out  4  sequence number of the next frame

## Operation
- Frame bytes in order: 0 SOF_BYTE; 1 header {seq[3:0], 3'b000, single}; 2 {2'b00,x1}; 3 {2'b00,y1}; 4 {2'b00,x2} or 8'hFF if single; 5 {2'b00,y2} or 8'hFF if single; 6 checksum = XOR of bytes 1..5.
- FSM states: IDLE, SOF, HDR, X1, Y1, X2, Y2, CHK. IDLE -> SOF on accepted legal move; each later state advances only on tx_valid && tx_ready; CHK -> IDLE on handshake, seq increments (mod 16, 15 -> 0).
- Accept = move_valid && move_ready. Move fields are registered on accept; inputs may change afterwards.
- Rejection (checked on accept): any used coordinate >= BOARD_SIZE, or double move with x1==x2 and y1==y2. Request is still consumed, err_range pulses next cycle, no frame, seq unchanged, FSM stays IDLE.
- Stone-2 fields are not checked when move_single=1.
- Reset values: move_ready 1, tx_valid 0, tx_data 0, tx_last 0, err_range 0, busy 0, seq_num 0, state IDLE.

## Timing
- Accept at cycle N -> tx_valid=1 with SOF at N+1; busy=1 from N+1 to the CHK handshake cycle inclusive.
- Stream rules: tx_valid, once high, stays high and tx_data/tx_last stay stable until tx_ready; no bubbles when tx_ready is held high (7 bytes in 7 consecutive cycles).
- move_ready=0 from N+1 until the cycle after the CHK handshake; back-to-back minimum spacing is 8 cycles accept-to-accept.
- tx_last=1 only while byte 6 is presented.
- rst_n assertion mid-frame: all outputs go to reset values immediately (asynchronous); partial frame abandoned, seq returns to 0.
- err_range and tx_valid are never high in the same cycle.

## Structure
- Shared package (connect6_pkg): BOARD_SIZE, SOF_BYTE, 8'hFF empty-stone code, frame length 7, state enum, coordinate width 6; the board intake decoder uses the same constants.
- One natural sub-module: move_check (combinational legality check: range and duplicate stone), reusable by the receive side.

## Test plan
- Double move (3,4),(5,6), seq 0, tx_ready=1 -> bytes A5 00 03 04 05 06 04, tx_last on last, seq_num becomes 1.
- Single move (9,9) with x2/y2=63, seq 0 -> A5 01 09 09 FF FF 01; no error.
- Move (19,0),(1,1) -> err_range pulse one cycle after accept, tx_valid stays 0, seq unchanged; also (7,7),(7,7) double -> rejected.
- tx_ready toggled randomly over a frame -> identical byte sequence, tx_data stable during stalls, move_ready low throughout.
- 17 back-to-back legal frames -> headers carry seq 0..15 then 0 (wrap).
- rst_n low during byte 3 -> tx_valid 0 immediately, seq_num 0; next move produces a complete fresh frame with header seq 0.

Source files
------------

// File: rtl/connect6_pkg.sv
// rtl/connect6_pkg.sv - shared Connect6 move-link constants, types and helpers
// Shared by the move transmit path and the board intake decoder.
// Contents: board geometry, frame marker/empty-stone codes, frame length,
// transmit FSM state enum, coordinate type and byte-packing helper.
package connect6_pkg;

    localparam int COORD_W    = 6;
    localparam int BOARD_SIZE = 19;
    localparam int FRAME_LEN  = 7;

    localparam logic [7:0] SOF_BYTE    = 8'hA5;
    localparam logic [7:0] EMPTY_STONE = 8'hFF;

    typedef logic [COORD_W-1:0] coord_t;

    // One state per presented frame byte, plus IDLE.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HDR,
        ST_X1,
        ST_Y1,
        ST_X2,
        ST_Y2,
        ST_CHK
    } tx_state_e;

    function automatic logic [7:0] coord_byte(input coord_t c);
        return {2'b00, c};
    endfunction

endpackage

// File: rtl/move_frame_tx_if.sv
// rtl/move_frame_tx_if.sv - move request handshake and byte stream bundle
// Signals:
//   move_valid/move_ready          move request handshake
//   move_single, move_x1..move_y2  move fields (stone 2 unused when single)
//   tx_data/tx_valid/tx_ready/tx_last  byte stream toward the link PHY
// Modports: slave = transmitter view, master = move source / stream sink view.
interface move_frame_tx_if;
    import connect6_pkg::*;

    logic       move_valid;
    logic       move_ready;
    logic       move_single;
    coord_t     move_x1;
    coord_t     move_y1;
    coord_t     move_x2;
    coord_t     move_y2;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport slave (
        input  move_valid, move_single, move_x1, move_y1, move_x2, move_y2,
        output move_ready,
        output tx_data, tx_valid, tx_last,
        input  tx_ready
    );

    modport master (
        output move_valid, move_single, move_x1, move_y1, move_x2, move_y2,
        input  move_ready,
        input  tx_data, tx_valid, tx_last,
        output tx_ready
    );

endinterface

// File: rtl/move_check.sv
// rtl/move_check.sv - combinational Connect6 move legality check
// Ports:
//   single_i        1 = one-stone move, stone 2 is not examined
//   x1_i,y1_i       stone 1 coordinates
//   x2_i,y2_i       stone 2 coordinates
//   legal_o         1 = all used coordinates on board and stones distinct
module move_check
    import connect6_pkg::*;
(
    input  logic   single_i,
    input  coord_t x1_i,
    input  coord_t y1_i,
    input  coord_t x2_i,
    input  coord_t y2_i,
    output logic   legal_o
);

    localparam coord_t LIMIT = COORD_W'(BOARD_SIZE);

    logic s1_ok;
    logic s2_ok;
    logic dup;

    always_comb begin
        s1_ok   = (x1_i < LIMIT) && (y1_i < LIMIT);
        s2_ok   = (x2_i < LIMIT) && (y2_i < LIMIT);
        dup     = (x1_i == x2_i) && (y1_i == y2_i);
        legal_o = s1_ok && (single_i || (s2_ok && !dup));
    end

endmodule

// File: rtl/move_frame_tx.sv
// rtl/move_frame_tx.sv - Connect6 move framer: checks a move and sends a 7-byte frame
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   mv           move request handshake in, framed byte stream out (slave view)
//   err_range    one-cycle pulse the cycle after an illegal move is consumed
//   busy         frame in progress (SOF presented through CHK handshake)
//   seq_num      sequence number carried by the next frame
module move_frame_tx
    import connect6_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    move_frame_tx_if.slave        mv,
    output logic                  err_range,
    output logic                  busy,
    output logic [3:0]            seq_num
);

    tx_state_e  state_q, state_d;
    logic [3:0] seq_q, seq_d;
    logic       err_q, err_d;

    logic       single_q;
    coord_t     x1_q, y1_q, x2_q, y2_q;

    logic       accept;
    logic       legal;
    logic       tx_fire;

    logic [7:0] hdr_byte;
    logic [7:0] x2_byte;
    logic [7:0] y2_byte;
    logic [7:0] chk_byte;

    move_check u_move_check (
        .single_i (mv.move_single),
        .x1_i     (mv.move_x1),
        .y1_i     (mv.move_y1),
        .x2_i     (mv.move_x2),
        .y2_i     (mv.move_y2),
        .legal_o  (legal)
    );

    assign accept  = mv.move_valid && mv.move_ready;
    assign tx_fire = mv.tx_valid && mv.tx_ready;

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Illegal requests are still consumed; they only raise the error pulse.
                if (accept) begin
                    if (legal) state_d = ST_SOF;
                    else       err_d   = 1'b1;
                end
            end
            ST_SOF: if (tx_fire) state_d = ST_HDR;
            ST_HDR: if (tx_fire) state_d = ST_X1;
            ST_X1:  if (tx_fire) state_d = ST_Y1;
            ST_Y1:  if (tx_fire) state_d = ST_X2;
            ST_X2:  if (tx_fire) state_d = ST_Y2;
            ST_Y2:  if (tx_fire) state_d = ST_CHK;
            ST_CHK: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                    seq_d   = seq_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            seq_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            err_q   <= err_d;
        end
    end

    // Move fields are captured only for frames that will actually be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            single_q <= 1'b0;
            x1_q     <= '0;
            y1_q     <= '0;
            x2_q     <= '0;
            y2_q     <= '0;
        end else if (accept && legal) begin
            single_q <= mv.move_single;
            x1_q     <= mv.move_x1;
            y1_q     <= mv.move_y1;
            x2_q     <= mv.move_x2;
            y2_q     <= mv.move_y2;
        end
    end

    always_comb begin
        hdr_byte = {seq_q, 3'b000, single_q};
        x2_byte  = single_q ? EMPTY_STONE : coord_byte(x2_q);
        y2_byte  = single_q ? EMPTY_STONE : coord_byte(y2_q);
        chk_byte = hdr_byte ^ coord_byte(x1_q) ^ coord_byte(y1_q) ^ x2_byte ^ y2_byte;
    end

    // Stream outputs decode straight from registered state, so they are stable
    // while stalled and drop to their reset values as soon as rst_n falls.
    always_comb begin
        mv.tx_data  = 8'h00;
        mv.tx_valid = 1'b1;
        mv.tx_last  = 1'b0;
        case (state_q)
            ST_IDLE: mv.tx_valid = 1'b0;
            ST_SOF:  mv.tx_data  = SOF_BYTE;
            ST_HDR:  mv.tx_data  = hdr_byte;
            ST_X1:   mv.tx_data  = coord_byte(x1_q);
            ST_Y1:   mv.tx_data  = coord_byte(y1_q);
            ST_X2:   mv.tx_data  = x2_byte;
            ST_Y2:   mv.tx_data  = y2_byte;
            ST_CHK: begin
                mv.tx_data = chk_byte;
                mv.tx_last = 1'b1;
            end
            default: mv.tx_valid = 1'b0;
        endcase
    end

    assign mv.move_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign err_range     = err_q;
    assign seq_num       = seq_q;

endmodule

// File: tb/tb_move_frame_tx.sv
// tb/tb_move_frame_tx.sv - self-checking bench for the move frame transmitter
module tb_move_frame_tx;
    import connect6_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_range;
    logic       busy;
    logic [3:0] seq_num;

    move_frame_tx_if bus();

    move_frame_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mv        (bus),
        .err_range (err_range),
        .busy      (busy),
        .seq_num   (seq_num)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         failures = 0;
    int         model_seq = 0;
    int         n_got;
    int         span;
    int         acc_cyc;
    logic       saw_err;
    logic [7:0] got [7];

    typedef struct {
        bit          single;
        int          x1, y1, x2, y2;
        bit          legal;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_legal(input int single, input int x1, input int y1,
                                       input int x2, input int y2);
        if (x1 >= BOARD_SIZE || y1 >= BOARD_SIZE) return 1'b0;
        if (single != 0) return 1'b1;
        if (x2 >= BOARD_SIZE || y2 >= BOARD_SIZE) return 1'b0;
        return !(x1 == x2 && y1 == y2);
    endfunction

    function automatic logic [7:0] model_byte(input int idx, input int single, input int x1,
                                              input int y1, input int x2, input int y2,
                                              input int seq);
        int b [7];
        b[0] = 'hA5;
        b[1] = (seq % 16) * 16 + single;
        b[2] = x1;
        b[3] = y1;
        b[4] = (single != 0) ? 255 : x2;
        b[5] = (single != 0) ? 255 : y2;
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        return 8'(b[idx]);
    endfunction

    task automatic idle_inputs();
        bus.move_valid  = 1'b0;
        bus.move_single = 1'($urandom);
        bus.move_x1     = 6'($urandom);
        bus.move_y1     = 6'($urandom);
        bus.move_x2     = 6'($urandom);
        bus.move_y2     = 6'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_move_ready", 32'(bus.move_ready), 32'd1);
        check("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
        check("rst_tx_data",    32'(bus.tx_data),    32'd0);
        check("rst_tx_last",    32'(bus.tx_last),    32'd0);
        check("rst_err",        32'(err_range),      32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_seq",        32'(seq_num),        32'd0);
        rst_n = 1'b1;
        model_seq = 0;
        @(negedge clk);
    endtask

    // Called at the negedge where the SOF byte is first presented.
    task automatic collect(input bit stall, input int stop_at);
        logic [7:0] held;
        bit         holding;
        int         budget;
        held = 8'h00;
        holding = 1'b0;
        n_got = 0;
        budget = 0;
        while (n_got < stop_at && budget < 300) begin
            if (holding) begin
                check("valid_held",   32'(bus.tx_valid), 32'd1);
                check("stall_stable", 32'(bus.tx_data),  32'(held));
            end
            if (bus.tx_valid) begin
                check("tx_last_pos",  32'(bus.tx_last), 32'(n_got == 6));
                check("ready_busy",   32'({bus.move_ready, busy}), 32'b01);
                check("err_vs_valid", 32'(err_range), 32'd0);
            end
            bus.tx_ready = stall ? 1'($urandom) : 1'b1;
            if (bus.tx_valid && bus.tx_ready) begin
                got[n_got] = bus.tx_data;
                n_got++;
                holding = 1'b0;
            end else if (bus.tx_valid) begin
                holding = 1'b1;
                held = bus.tx_data;
            end
            @(negedge clk);
            budget++;
        end
        span = budget;
        check("frame_budget", 32'(n_got >= stop_at), 32'd1);
    endtask

    task automatic run_move(input int single, input int x1, input int y1, input int x2,
                            input int y2, input bit stall);
        bit legal;
        legal = model_legal(single, x1, y1, x2, y2);
        check("move_ready_idle", 32'(bus.move_ready), 32'd1);
        bus.move_valid  = 1'b1;
        bus.move_single = 1'(single);
        bus.move_x1     = 6'(x1);
        bus.move_y1     = 6'(y1);
        bus.move_x2     = 6'(x2);
        bus.move_y2     = 6'(y2);
        acc_cyc = cyc;
        @(negedge clk);
        idle_inputs();
        saw_err = err_range;
        if (legal) begin
            check("sof_latency", 32'(bus.tx_valid), 32'd1);
            check("err_quiet",   32'(saw_err), 32'd0);
            collect(stall, 7);
            for (int i = 0; i < 7; i++)
                check("frame_byte", 32'(got[i]), 32'(model_byte(i, single, x1, y1, x2, y2, model_seq)));
            model_seq = (model_seq + 1) % 16;
            check("ready_after", 32'(bus.move_ready), 32'd1);
            check("busy_after",  32'(busy), 32'd0);
            check("valid_after", 32'(bus.tx_valid), 32'd0);
            check("seq_after",   32'(seq_num), 32'(model_seq));
            if (!stall) check("no_bubble", 32'(span), 32'd7);
        end else begin
            check("err_pulse",      32'(saw_err), 32'd1);
            check("rej_tx_valid",   32'(bus.tx_valid), 32'd0);
            check("rej_busy",       32'(busy), 32'd0);
            check("rej_move_ready", 32'(bus.move_ready), 32'd1);
            @(negedge clk);
            check("err_one_cycle",  32'(err_range), 32'd0);
            check("rej_seq",        32'(seq_num), 32'(model_seq));
            check("rej_valid_late", 32'(bus.tx_valid), 32'd0);
        end
    endtask

    initial begin
        int prev;
        int s, a, b, c, d;
        vecs[0] = '{0,  3,  4,  5,  6, 1, 56'hA5_00_03_04_05_06_04};
        vecs[1] = '{0, 19,  0,  1,  1, 0, 56'h0};
        vecs[2] = '{0,  7,  7,  7,  7, 0, 56'h0};
        vecs[3] = '{1,  9,  9, 63, 63, 1, 56'hA5_11_09_09_FF_FF_11};
        vecs[4] = '{1, 18,  0, 18,  0, 1, 56'hA5_21_12_00_FF_FF_33};
        vecs[5] = '{1, 19,  5,  0,  0, 0, 56'h0};
        vecs[6] = '{0, 18, 18,  0,  0, 1, 56'hA5_30_12_12_00_00_30};
        vecs[7] = '{0,  0,  0,  0,  1, 1, 56'hA5_40_00_00_00_01_41};
        vecs[8] = '{0,  5,  5,  5, 19, 0, 56'h0};
        vecs[9] = '{0,  0, 18, 63,  2, 0, 56'h0};

        bus.tx_ready = 1'b0;
        idle_inputs();
        do_reset();

        // Fixed vectors with hand-derived frames
        foreach (vecs[k]) begin
            run_move(int'(vecs[k].single), vecs[k].x1, vecs[k].y1, vecs[k].x2, vecs[k].y2, 1'b0);
            check("tbl_reject", 32'(saw_err), 32'(!vecs[k].legal));
            if (vecs[k].legal)
                for (int i = 0; i < 7; i++)
                    check("tbl_byte", 32'(got[i]), 32'(vecs[k].exp[55 - 8*i -: 8]));
        end

        // Random moves under random downstream stalls
        for (int k = 0; k < 8; k++) begin
            s = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, 21));
            b = int'($urandom_range(0, 21));
            c = int'($urandom_range(0, 21));
            d = int'($urandom_range(0, 21));
            if (k == 3) begin s = 0; c = a; d = b; end
            run_move(s, a, b, c, d, 1'b1);
        end

        // 17 back-to-back frames: sequence wraps 15 -> 0, 8-cycle spacing
        do_reset();
        prev = 0;
        for (int k = 0; k < 17; k++) begin
            s = int'($urandom_range(0, 1));
            a = int'($urandom_range(0, 18));
            b = int'($urandom_range(0, 18));
            c = int'($urandom_range(0, 18));
            d = int'($urandom_range(0, 18));
            if (a == c && b == d) d = (b + 1) % 19;
            run_move(s, a, b, c, d, 1'b0);
            check("wrap_hdr_seq", 32'(got[1][7:4]), 32'(k % 16));
            if (k > 0) check("b2b_spacing", 32'(acc_cyc - prev), 32'd8);
            prev = acc_cyc;
        end

        // Reset while byte 3 is presented
        bus.move_valid  = 1'b1;
        bus.move_single = 1'b0;
        bus.move_x1     = 6'd2;
        bus.move_y1     = 6'd3;
        bus.move_x2     = 6'd4;
        bus.move_y2     = 6'd5;
        @(negedge clk);
        idle_inputs();
        check("rst_mid_sof", 32'(bus.tx_valid), 32'd1);
        collect(1'b0, 3);
        check("rst_mid_byte3", 32'(bus.tx_data), 32'h03);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_mid_seq",   32'(seq_num), 32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_ready", 32'(bus.move_ready), 32'd1);
        check("rst_mid_data",  32'(bus.tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_seq = 0;
        @(negedge clk);
        run_move(1, 9, 9, 63, 63, 1'b0);
        for (int i = 0; i < 7; i++)
            check("fresh_frame", 32'(got[i]), 32'(model_byte(i, 1, 9, 9, 63, 63, 0)));
        check("fresh_chk", 32'(got[6]), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
